// File: rtl/ex_wb_stage.sv
// Execute + write-back stage: captures RF operands (with EX/WB forwarding),
// runs a single-cycle ALU op or a DW-cycle shift-add multiply, and drives
// the register-file write port together with Zero/Carry flags.
module ex_wb_stage #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Valid_in,
  output logic          Ready,
  input  logic [2:0]    Opcode,
  input  logic [AW-1:0] Raddr_a,
  input  logic [AW-1:0] Raddr_b,
  input  logic [DW-1:0] Rf_a,
  input  logic [DW-1:0] Rf_b,
  input  logic [DW-1:0] Imm,
  input  logic          Use_imm,
  input  logic [AW-1:0] Dest,
  output logic          We,
  output logic [AW-1:0] Waddr,
  output logic [DW-1:0] Wdata,
  output logic          Zero,
  output logic          Carry
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          mul_done_c;

  logic          ex_valid;
  logic [2:0]    ex_op;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [AW-1:0] ex_dest;

  logic [DW-1:0] mul_acc;
  logic [DW-1:0] mul_mcand;
  logic [DW-1:0] mul_mplier;
  logic [DW-1:0] mul_sum_c;

  logic [DW:0]   sum_c;
  logic [DW-1:0] alu_res_c;
  logic          alu_carry_c;

  logic [DW-1:0] op_a_c;
  logic [DW-1:0] op_b_c;
  logic          accept_c;

  assign accept_c = Valid_in & Ready;

  // Single-cycle ALU on the EX register contents
  always_comb begin
    sum_c       = '0;
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    case (ex_op)
      OP_ADD: begin
        sum_c       = {1'b0, ex_a} + {1'b0, ex_b};
        alu_res_c   = sum_c[DW-1:0];
        alu_carry_c = sum_c[DW];
      end
      OP_SUB: begin
        sum_c       = {1'b0, ex_a} - {1'b0, ex_b};
        alu_res_c   = sum_c[DW-1:0];
        alu_carry_c = sum_c[DW];
      end
      OP_AND:  alu_res_c = ex_a & ex_b;
      OP_OR:   alu_res_c = ex_a | ex_b;
      OP_XOR:  alu_res_c = ex_a ^ ex_b;
      OP_SHL:  alu_res_c = ex_a << ex_b[2:0];
      OP_MOV:  alu_res_c = ex_b;
      default: alu_res_c = '0;
    endcase
  end

  // Operand select: EX result beats WB data beats RF read; immediate bypasses B
  always_comb begin
    op_a_c = Rf_a;
    if (We && (Waddr == Raddr_a)) op_a_c = Wdata;
    if (ex_valid && (ex_dest == Raddr_a)) op_a_c = alu_res_c;
    op_b_c = Rf_b;
    if (We && (Waddr == Raddr_b)) op_b_c = Wdata;
    if (ex_valid && (ex_dest == Raddr_b)) op_b_c = alu_res_c;
    if (Use_imm) op_b_c = Imm;
  end

  // One shift-add step: add multiplicand when current multiplier bit is set
  always_comb begin
    mul_sum_c = mul_acc;
    if (mul_mplier[0]) mul_sum_c = mul_acc + mul_mcand;
  end

  // Multiply FSM next-state and bit counter
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mul_done_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept_c && (Opcode == OP_MUL)) begin
          state_nxt = S_MUL;
          cnt_nxt   = '0;
        end
      end
      S_MUL: begin
        if (cnt == CW'(DW - 1)) begin
          mul_done_c = 1'b1;
          state_nxt  = S_IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state, counter and registered Ready
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      Ready <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Ready <= (state_nxt == S_IDLE);
    end
  end

  // EX register; a MUL keeps its destination here but never marks EX valid
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_valid <= 1'b0;
      ex_op    <= OP_ADD;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_dest  <= '0;
    end else begin
      ex_valid <= accept_c && (Opcode != OP_MUL);
      if (accept_c) begin
        ex_op   <= Opcode;
        ex_a    <= op_a_c;
        ex_b    <= op_b_c;
        ex_dest <= Dest;
      end
    end
  end

  // Multiplier datapath: accumulator, shifting multiplicand and multiplier
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
    end else if (accept_c && (Opcode == OP_MUL)) begin
      mul_acc    <= '0;
      mul_mcand  <= op_a_c;
      mul_mplier <= op_b_c;
    end else if (state == S_MUL) begin
      mul_acc    <= mul_sum_c;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
    end
  end

  // WB register and flags; flags only move on a writing edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      We    <= 1'b0;
      Waddr <= '0;
      Wdata <= '0;
      Zero  <= 1'b0;
      Carry <= 1'b0;
    end else if (ex_valid) begin
      We    <= 1'b1;
      Waddr <= ex_dest;
      Wdata <= alu_res_c;
      Zero  <= (alu_res_c == '0);
      Carry <= alu_carry_c;
    end else if (mul_done_c) begin
      We    <= 1'b1;
      Waddr <= ex_dest;
      Wdata <= mul_sum_c;
      Zero  <= (mul_sum_c == '0);
      Carry <= 1'b0;
    end else begin
      We <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: reset, forwarding chains, flags, MUL
// stall/forward, and reset aborting a multiply.
module tb_ex_wb_stage;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] MOV = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  logic       Clk;
  logic       Rst;
  logic       Valid_in;
  logic       Ready;
  logic [2:0] Opcode;
  logic [2:0] Raddr_a;
  logic [2:0] Raddr_b;
  logic [7:0] Rf_a;
  logic [7:0] Rf_b;
  logic [7:0] Imm;
  logic       Use_imm;
  logic [2:0] Dest;
  logic       We;
  logic [2:0] Waddr;
  logic [7:0] Wdata;
  logic       Zero;
  logic       Carry;

  int checks = 0;
  int errors = 0;

  ex_wb_stage #(.DW(8), .AW(3)) dut (
    .Clk(Clk), .Rst(Rst), .Valid_in(Valid_in), .Ready(Ready),
    .Opcode(Opcode), .Raddr_a(Raddr_a), .Raddr_b(Raddr_b),
    .Rf_a(Rf_a), .Rf_b(Rf_b), .Imm(Imm), .Use_imm(Use_imm), .Dest(Dest),
    .We(We), .Waddr(Waddr), .Wdata(Wdata), .Zero(Zero), .Carry(Carry)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [7:0] fa, input logic [7:0] fb,
                       input logic [7:0] im, input logic ui, input logic [2:0] d);
    Valid_in = v;
    Opcode   = op;
    Raddr_a  = ra;
    Raddr_b  = rb;
    Rf_a     = fa;
    Rf_b     = fb;
    Imm      = im;
    Use_imm  = ui;
    Dest     = d;
  endtask

  task automatic wb(input string tag, input logic we, input logic [2:0] wa,
                    input logic [7:0] wd, input logic z, input logic c);
    chk({tag, ".we"}, 16'(We), 16'(we));
    chk({tag, ".waddr"}, 16'(Waddr), 16'(wa));
    chk({tag, ".wdata"}, 16'(Wdata), 16'(wd));
    chk({tag, ".zero"}, 16'(Zero), 16'(z));
    chk({tag, ".carry"}, 16'(Carry), 16'(c));
  endtask

  initial begin
    // Reset held two cycles with a valid instruction presented
    Rst = 1'b1;
    drive(1'b1, ADD, 3'd0, 3'd0, 8'd3, 8'd3, 8'd5, 1'b1, 3'd1);
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst.we", 16'(We), 16'd0);
      chk("rst.ready", 16'(Ready), 16'd1);
      chk("rst.zero", 16'(Zero), 16'd0);
      chk("rst.carry", 16'(Carry), 16'd0);
    end
    Rst = 1'b0;

    // ADD r1=r0+5 (r0=3); ADD r2=r1+r1 via EX path; SUB r3=r2-r1 via EX and WB paths
    drive(1'b1, ADD, 3'd0, 3'd0, 8'd3, 8'd0, 8'd5, 1'b1, 3'd1);
    tick;
    chk("add1.we_early", 16'(We), 16'd0);
    drive(1'b1, ADD, 3'd1, 3'd1, 8'd0, 8'd0, 8'd0, 1'b0, 3'd2);
    tick;
    wb("add1", 1'b1, 3'd1, 8'd8, 1'b0, 1'b0);
    drive(1'b1, SUB, 3'd2, 3'd1, 8'd0, 8'd0, 8'd0, 1'b0, 3'd3);
    tick;
    wb("add2", 1'b1, 3'd2, 8'd16, 1'b0, 1'b0);
    drive(1'b0, ADD, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    tick;
    wb("sub3", 1'b1, 3'd3, 8'd8, 1'b0, 1'b0);
    tick;
    chk("bubble.we", 16'(We), 16'd0);

    // Same dest back-to-back, EX beats WB, borrow, then XOR to zero
    drive(1'b1, MOV, 3'd0, 3'd0, 8'd0, 8'd0, 8'h06, 1'b1, 3'd4);
    tick;
    drive(1'b1, MOV, 3'd0, 3'd0, 8'd0, 8'd0, 8'h05, 1'b1, 3'd4);
    tick;
    wb("mov6", 1'b1, 3'd4, 8'h06, 1'b0, 1'b0);
    drive(1'b1, SUB, 3'd4, 3'd0, 8'h77, 8'd0, 8'h06, 1'b1, 3'd5);
    tick;
    wb("mov5", 1'b1, 3'd4, 8'h05, 1'b0, 1'b0);
    drive(1'b1, XOR, 3'd5, 3'd5, 8'h5A, 8'h3C, 8'd0, 1'b0, 3'd6);
    tick;
    wb("sub_borrow", 1'b1, 3'd5, 8'hFF, 1'b0, 1'b1);
    drive(1'b0, ADD, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    tick;
    wb("xor_zero", 1'b1, 3'd6, 8'h00, 1'b1, 1'b0);
    tick;
    wb("flags_hold", 1'b0, 3'd6, 8'h00, 1'b1, 1'b0);

    // MUL r7 = 0x0F * 0x11 with dependent ADD r0 = r7 + 1 held upstream
    drive(1'b1, MUL, 3'd1, 3'd2, 8'h0F, 8'h11, 8'd0, 1'b0, 3'd7);
    tick;
    drive(1'b1, ADD, 3'd7, 3'd0, 8'd0, 8'd0, 8'd1, 1'b1, 3'd0);
    chk("mul.ready_first", 16'(Ready), 16'd0);
    chk("mul.we_first", 16'(We), 16'd0);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk($sformatf("mul.ready_c%0d", i), 16'(Ready), 16'd0);
      chk($sformatf("mul.we_c%0d", i), 16'(We), 16'd0);
    end
    tick;
    wb("mul_done", 1'b1, 3'd7, 8'hFF, 1'b0, 1'b0);
    chk("mul_done.ready", 16'(Ready), 16'd1);
    tick;
    drive(1'b0, ADD, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    chk("dep_add.we_early", 16'(We), 16'd0);
    tick;
    wb("dep_add", 1'b1, 3'd0, 8'h00, 1'b1, 1'b1);

    // Reset mid-MUL at cnt=3 aborts it; then a fresh ADD completes
    drive(1'b1, MUL, 3'd1, 3'd2, 8'h03, 8'h03, 8'd0, 1'b0, 3'd3);
    tick;
    drive(1'b0, ADD, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("abort.ready_c%0d", i), 16'(Ready), 16'd0);
    end
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    wb("abort_rst", 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    chk("abort_rst.ready", 16'(Ready), 16'd1);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("abort.no_we_%0d", i), 16'(We), 16'd0);
      chk($sformatf("abort.ready_%0d", i), 16'(Ready), 16'd1);
    end
    drive(1'b1, ADD, 3'd1, 3'd0, 8'h10, 8'd0, 8'h04, 1'b1, 3'd2);
    tick;
    drive(1'b0, ADD, 3'd0, 3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 3'd0);
    tick;
    wb("post_rst_add", 1'b1, 3'd2, 8'h14, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
